// File: rtl/div_unit_pkg.sv
// Shared widths, FSM encoding and operand helpers for the EX-stage divider.
package div_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned DBL_W  = 2 * DATA_W;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Magnitude of an operand; unsigned operands pass through untouched.
  function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] v,
                                               input logic              is_signed);
    return (is_signed && v[DATA_W-1]) ? DATA_W'(-v) : v;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: trial subtract, keep or restore, emit quotient bit.
module div_unit_step
  import div_unit_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_c,
  output logic         q_bit_c
);

  logic [W+1:0] diff;

  // The partial remainder carries one extra bit: with a divisor above 2^(W-1)
  // the shifted remainder can exceed W bits before the subtraction.
  always_comb begin
    diff    = {1'b0, rem_i} - {2'b00, divisor_i};
    q_bit_c = ~diff[W+1];
    rem_c   = q_bit_c ? diff[W-1:0] : rem_i[W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with annul and held result.
// Optional feature macro: DIV_ZERO_FLAG_EN adds the div_zero_o flag output.
module div_unit
  import div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_div_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic [DBL_W-1:0]  result_o,
`ifdef DIV_ZERO_FLAG_EN
  output logic              div_zero_o,
`endif
  output logic              ready_o
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DBL_W:0]    dividend_q, dividend_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic              neg_quot_q, neg_quot_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DBL_W-1:0]  result_q, result_d;
  logic              ready_q, ready_d;
`ifdef DIV_ZERO_FLAG_EN
  logic              div_zero_q, div_zero_d;
`endif

  logic [DATA_W-1:0] step_rem_c;
  logic              step_q_bit_c;
  logic [DATA_W-1:0] quot_fix, rem_fix;
  logic [DATA_W-1:0] abs1, abs2;

  div_unit_step #(.W(DATA_W)) u_step (
    .rem_i     (dividend_q[DBL_W:DATA_W]),
    .divisor_i (divisor_q),
    .rem_c     (step_rem_c),
    .q_bit_c   (step_q_bit_c)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = '0;
    ready_d    = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
    div_zero_d = 1'b0;
`endif
    abs1       = abs_op(opdata1_i, signed_div_i);
    abs2       = abs_op(opdata2_i, signed_div_i);
    quot_fix   = dividend_q[DATA_W-1:0];
    rem_fix    = dividend_q[DBL_W:DATA_W+1];

    unique case (state_q)
      DIV_FREE: begin
        if (start_i && !annul_i) begin
          neg_quot_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d  = signed_div_i & opdata1_i[DATA_W-1];
          divisor_d  = abs2;
          dividend_d = {DATA_W'(0), abs1, 1'b0};
          cnt_d      = '0;
          state_d    = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end

      DIV_BY_ZERO: begin
        dividend_d = '0;
        state_d    = DIV_END;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          dividend_d = {step_rem_c, dividend_q[DATA_W-1:0], step_q_bit_c};
          cnt_d      = cnt_q + CNT_W'(1);
        end else begin
          if (neg_quot_q) quot_fix = DATA_W'(-quot_fix);
          if (neg_rem_q)  rem_fix  = DATA_W'(-rem_fix);
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
          cnt_d    = '0;
          state_d  = DIV_END;
        end
      end

      DIV_END: begin
        if (start_i) begin
          result_d = result_q;
          ready_d  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
          div_zero_d = (divisor_q == '0);
`endif
        end else begin
          state_d = DIV_FREE;
        end
      end

      default: state_d = DIV_FREE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero_o = div_zero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed cases, annul, mid-op reset, random pairs.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero;
`endif

  typedef struct packed {
    logic [63:0] res;
    logic        zero;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
`ifdef DIV_ZERO_FLAG_EN
    .div_zero_o   (div_zero),
`endif
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  // Truncating division reference; remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  // Full handshake: optional start/annul collision cycles, start, latency,
  // result against scoreboard, hold while start high, clear after drop.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res,
                        input int collide);
    exp_t e;
    int   k;
    e.res  = exp_res;
    e.zero = (b == 32'h0);
    sb_q.push_back(e);
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    for (int i = 0; i < collide; i++) begin
      annul = 1'b1;
      step_edge();
      check({tag, "_collide_rdy"}, 64'(ready), 64'h0);
    end
    annul = 1'b0;
    step_edge();
    op1        = $urandom;
    op2        = $urandom;
    signed_div = 1'($urandom_range(0, 1));
    k = 0;
    while (!ready && k < 64) begin
      step_edge();
      k++;
    end
    check({tag, "_lat"}, 64'(k), (b == 32'h0) ? 64'd2 : 64'd33);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_res"}, result, e.res);
`ifdef DIV_ZERO_FLAG_EN
      check({tag, "_dz"}, 64'(div_zero), 64'(e.zero));
`endif
    end
    step_edge();
    check({tag, "_hold_rdy"}, 64'(ready), 64'h1);
    check({tag, "_hold_res"}, result, e.res);
    start = 1'b0;
    step_edge();
    check({tag, "_drop_rdy"}, 64'(ready), 64'h0);
    check({tag, "_drop_res"}, result, 64'h0);
`ifdef DIV_ZERO_FLAG_EN
    check({tag, "_drop_dz"}, 64'(div_zero), 64'h0);
`endif
  endtask

  initial begin
    int rises;
    logic        sgn;
    logic [31:0] a, b;
    int          sel;

    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (3) step_edge();
    check("reset_rdy", 64'(ready), 64'h0);
    check("reset_res", result, 64'h0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset_dz", 64'(div_zero), 64'h0);
`endif
    rst = 1'b0;
    step_edge();

    do_div("divu_100_7",  1'b0, 32'd100,        32'd7,          {32'h2, 32'hE}, 0);
    do_div("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    do_div("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h1, 32'hFFFF_FFFD}, 0);
    do_div("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000}, 0);
    do_div("div_5_0",     1'b1, 32'd5,          32'd0,          64'h0, 0);
    do_div("divu_big",    1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  {32'h7FFF_FFFE, 32'h1}, 0);

    // Annul at iteration 10: the result must never appear.
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    step_edge();
    repeat (10) step_edge();
    annul = 1'b1; start = 1'b0;
    step_edge();
    annul = 1'b0;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      step_edge();
      if (ready) rises++;
    end
    check("annul_no_rdy", 64'(rises), 64'h0);
    do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 0);

    // Reset at iteration 20 clears everything.
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    step_edge();
    repeat (20) step_edge();
    rst = 1'b1;
    step_edge();
    check("midrst_rdy", 64'(ready), 64'h0);
    check("midrst_res", result, 64'h0);
    rst = 1'b0; start = 1'b0;
    step_edge();
    do_div("after_rst_ffff_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 0);
    do_div("collide_20_6",     1'b1, 32'd20,        32'hFFFF_FFFA, {32'd2, 32'hFFFF_FFFD}, 3);

    for (int n = 0; n < 250; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        4: b = b >> $urandom_range(1, 30);
        default: ;
      endcase
      do_div("rand", sgn, a, b, ref_div(sgn, a, b), ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    check("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
